// File: rtl/fnd_run_controller.sv
// Run/stop/clear controller and 0..9999 up/down count source for the FND display.
// Three raw buttons are synchronised, debounced and edge-detected; a small FSM
// gates a tick prescaler that steps the binary count feeding the digit divider.

// Per-button conditioner: 2-FF synchroniser, debouncer, registered rising-edge pulse.
module fnd_btn_cond #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_pulse
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          r_s1, r_s2, r_stable, r_prev, r_pulse;
    logic [DW-1:0] r_cnt;

    // Sync, accept a level only after DEBOUNCE_CYCLES differing samples, then pulse on 0->1.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_prev   <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_prev  <= r_stable;
            r_pulse <= r_stable & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;
endmodule

module fnd_run_controller #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 10,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_btn_run,
    input  logic        i_btn_clear,
    input  logic        i_btn_mode,
    output logic [13:0] o_counter,
    output logic        o_running,
    output logic        o_down
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [13:0] MAXC = 14'd9999;

    typedef enum logic [1:0] {S_STOP, S_RUN, S_CLEAR} state_t;

    // Bit 0 = run, 1 = clear, 2 = mode.
    logic [2:0] w_btn, w_pulse;
    assign w_btn = {i_btn_mode, i_btn_clear, i_btn_run};

    for (genvar g = 0; g < 3; g++) begin : g_btn
        fnd_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_btn   (w_btn[g]),
            .o_pulse (w_pulse[g])
        );
    end

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [13:0]   r_counter;
    logic          r_running, r_down;
    logic          w_run_p, w_clear_p, w_mode_p, w_tick;

    assign w_run_p   = w_pulse[0];
    assign w_clear_p = w_pulse[1];
    assign w_mode_p  = w_pulse[2];
    assign w_tick    = (r_state == S_RUN) && (r_presc == PW'(DIV - 1));

    // Control FSM with prescaler and count; tick uses the direction held before any toggle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_STOP;
            r_presc   <= '0;
            r_counter <= '0;
            r_running <= 1'b0;
            r_down    <= 1'b0;
        end else begin
            if (w_mode_p)
                r_down <= ~r_down;
            if (w_clear_p) begin
                r_state   <= S_CLEAR;
                r_running <= 1'b0;
                r_counter <= '0;
                r_presc   <= '0;
            end else begin
                if (w_tick) begin
                    if (r_down)
                        r_counter <= (r_counter == 14'd0) ? MAXC : r_counter - 14'd1;
                    else
                        r_counter <= (r_counter == MAXC) ? 14'd0 : r_counter + 14'd1;
                end
                case (r_state)
                    S_STOP: begin
                        if (w_run_p) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        r_presc <= w_tick ? '0 : r_presc + 1'b1;
                        if (w_run_p) begin
                            r_state   <= S_STOP;
                            r_running <= 1'b0;
                        end
                    end
                    S_CLEAR: begin
                        r_state   <= S_STOP;
                        r_running <= 1'b0;
                    end
                    default: begin
                        r_state   <= S_STOP;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_counter = r_counter;
    assign o_running = r_running;
    assign o_down    = r_down;
endmodule
